// File: rtl/alu_mc_if.sv
// Operand/result bundle between the datapath control and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  // A transfer happens on a rising edge where in_valid && in_ready; out_valid is a
  // one-cycle completion pulse with no back-pressure from the consumer.
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             src_a_sel;
  logic             src_b_sel;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic [SHW-1:0]   sa;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output in_valid, op, src_a_sel, src_b_sel, rdata1, rdata2, sa, imm,
    input  in_ready, out_valid, result, zero, hi, lo, div_by_zero
  );

  modport slave (
    input  in_valid, op, src_a_sel, src_b_sel, rdata1, rdata2, sa, imm,
    output in_ready, out_valid, result, zero, hi, lo, div_by_zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops plus iterative shift-add
// multiply and restoring divide that write the HI/LO pair.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_mc_if.slave    bus,
  output logic [1:0] dbg_state
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo, dividend;
  logic             mode_div, neg_q, neg_r, dvz;

  logic [WIDTH-1:0] a_val, b_val, diff, alu_res, a_mag, b_mag;
  logic [SHW-1:0]   shamt;
  logic             slt, signed_op;

  assign bus.in_ready = (state == IDLE);
  assign dbg_state    = state;

  always_comb begin
    a_val     = bus.src_a_sel ? {{(WIDTH-SHW){1'b0}}, bus.sa} : bus.rdata1;
    b_val     = bus.src_b_sel ? bus.imm : bus.rdata2;
    shamt     = a_val[SHW-1:0];
    diff      = a_val - b_val;
    // Differing signs decide SLT directly, so the subtraction never overflows into it.
    slt       = (a_val[WIDTH-1] != b_val[WIDTH-1]) ? a_val[WIDTH-1] : diff[WIDTH-1];
    signed_op = ~bus.op[0];
    a_mag     = (signed_op && a_val[WIDTH-1]) ? -a_val : a_val;
    b_mag     = (signed_op && b_val[WIDTH-1]) ? -b_val : b_val;
    case (bus.op)
      4'b0001: alu_res = a_val + b_val;
      4'b0010: alu_res = diff;
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'b0100: alu_res = a_val & b_val;
      4'b0101: alu_res = ~(a_val | b_val);
      4'b0110: alu_res = a_val | b_val;
      4'b0111: alu_res = a_val ^ b_val;
      4'b1000: alu_res = b_val << shamt;
      4'b1001: alu_res = b_val >> shamt;
      4'b1010: alu_res = $signed(b_val) >>> shamt;
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, (a_val < b_val)};
      default: alu_res = b_val;
    endcase
  end

  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] trial;
  logic             ge;

  // One shift-add or restoring-subtract step over the {acc_hi, acc_lo} pair.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, opnd});
    trial   = rem_sh[WIDTH-1:0] - opnd;
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    if (!mode_div) begin
      {fix_hi, fix_lo} = prod_fix;
    end else if (dvz) begin
      fix_lo = {WIDTH{1'b1}};
      fix_hi = dividend;
    end else begin
      fix_lo = neg_q ? -acc_lo : acc_lo;
      fix_hi = neg_r ? -acc_hi : acc_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      opnd            <= '0;
      acc_hi          <= '0;
      acc_lo          <= '0;
      dividend        <= '0;
      mode_div        <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dvz             <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.result      <= '0;
      bus.zero        <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.op[3:2] == 2'b11) begin
              state    <= bus.op[1] ? DIV : MUL;
              mode_div <= bus.op[1];
              cnt      <= SHW'(WIDTH - 1);
              opnd     <= b_mag;
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              neg_q    <= signed_op & (a_val[WIDTH-1] ^ b_val[WIDTH-1]);
              neg_r    <= signed_op & a_val[WIDTH-1];
              dvz      <= bus.op[1] & (b_val == '0);
              dividend <= a_val;
            end else begin
              bus.out_valid   <= 1'b1;
              bus.result      <= alu_res;
              bus.zero        <= (alu_res == '0);
              bus.div_by_zero <= 1'b0;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - SHW'(1);
        end
        DIV: begin
          acc_hi <= ge ? trial : rem_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], ge};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - SHW'(1);
        end
        FIX: begin
          bus.hi          <= fix_hi;
          bus.lo          <= fix_lo;
          bus.result      <= fix_lo;
          bus.zero        <= (fix_lo == '0);
          bus.div_by_zero <= mode_div & dvz;
          bus.out_valid   <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
